// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Capture stage behind the 8-bit ALU. On a capture strobe it stores the ALU
//   result together with its zero/carry flags in a small first-word-fall-through
//   FIFO. Stored results survive later operand changes and are drained one per
//   pop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   capture    push request for {y_in, zero_in, carry_in}
//   y_in       ALU result word
//   zero_in    ALU zero flag
//   carry_in   ALU carry flag
//   in_ready   FIFO not full
//   pop        consume the head entry
//   out_valid  FIFO not empty, head on out_* is valid
//   out_data   head result (0 when empty)
//   out_zero   head zero flag (0 when empty)
//   out_carry  head carry flag (0 when empty)
//   count      number of stored entries
//   drop_err   sticky flag: a capture arrived while the FIFO was full
//   clr        synchronous clear of FIFO, drop_err and accumulator
//   acc_sum    running 16-bit wrap-around sum of accepted results
//
// Configuration
//   RESULT_ACC_EN  when defined, builds the result accumulator behind acc_sum;
//                  otherwise acc_sum is tied to zero.
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [DATA_W-1:0] y_in,
    input  logic              zero_in,
    input  logic              carry_in,
    output logic              in_ready,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_carry,
    output logic [CNT_W-1:0]  count,
    output logic              drop_err,
    input  logic              clr,
    output logic [15:0]       acc_sum
);

    // Each entry packs {result, zero, carry}.
    logic [DATA_W+1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop_ok;
    logic [DATA_W+1:0] head;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    // clr overrides both directions so a clearing cycle never moves data.
    assign push   = capture & in_ready & ~clr;
    assign pop_ok = pop & out_valid & ~clr;

    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_data  = head[DATA_W+1:2];
    assign out_zero  = head[1];
    assign out_carry = head[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {y_in, zero_in, carry_in};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A capture refused for lack of space latches the error until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (clr) begin
            drop_err <= 1'b0;
        end else if (capture && !in_ready) begin
            drop_err <= 1'b1;
        end
    end

`ifdef RESULT_ACC_EN
    logic [15:0] acc;

    // 16-bit sum wraps modulo 2^16 by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (push) begin
            acc <= acc + 16'(y_in);
        end
    end

    assign acc_sum = acc;
`else
    assign acc_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Directed self-checking bench for alu_result_fifo (DATA_W=8, DEPTH=4).
//   Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       capture;
    logic [7:0] y_in;
    logic       zero_in;
    logic       carry_in;
    logic       in_ready;
    logic       pop;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_carry;
    logic [2:0] count;
    logic       drop_err;
    logic       clr;
    logic [15:0] acc_sum;

    int n_chk;
    int n_bad;

    alu_result_fifo #(
        .DATA_W(8),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .y_in     (y_in),
        .zero_in  (zero_in),
        .carry_in (carry_in),
        .in_ready (in_ready),
        .pop      (pop),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_zero (out_zero),
        .out_carry(out_carry),
        .count    (count),
        .drop_err (drop_err),
        .clr      (clr),
        .acc_sum  (acc_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d, input logic z, input logic c);
        capture  = 1'b1;
        y_in     = d;
        zero_in  = z;
        carry_in = c;
        step();
        capture  = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Check head entry {data, zero, carry} before popping it.
    task automatic chk_head(input string tag, input logic [7:0] d, input logic z, input logic c);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_zero"},  32'(out_zero),  32'(z));
        chk({tag, "_carry"}, 32'(out_carry), 32'(c));
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        capture  = 1'b0;
        y_in     = 8'h00;
        zero_in  = 1'b0;
        carry_in = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1. Reset then idle
        chk("rst_count",  32'(count),     32'd0);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_ready",  32'(in_ready),  32'd1);
        chk("rst_drop",   32'(drop_err),  32'd0);
        chk("rst_data",   32'(out_data),  32'h00);
        chk("rst_acc",    32'(acc_sum),   32'h0000);
        pop_one();  // empty pop: ignored
        chk("empty_pop_count", 32'(count),    32'd0);
        chk("empty_pop_drop",  32'(drop_err), 32'd0);

        // 2. Order and flags preserved
        push_one(8'h12, 1'b0, 1'b0);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_data",  32'(out_data),  32'h12);
        push_one(8'h00, 1'b1, 1'b0);
        push_one(8'hFF, 1'b0, 1'b1);
        chk("t2_count", 32'(count), 32'd3);
        chk_head("t2_h0", 8'h12, 1'b0, 1'b0);
        pop_one();
        chk_head("t2_h1", 8'h00, 1'b1, 1'b0);
        pop_one();
        chk_head("t2_h2", 8'hFF, 1'b0, 1'b1);
        pop_one();
        chk("t2_empty_valid", 32'(out_valid), 32'd0);
        chk("t2_empty_data",  32'(out_data),  32'h00);
        chk("t2_empty_carry", 32'(out_carry), 32'd0);

        // 3. Full, overflow drop, sticky error
        for (int i = 0; i < 4; i++) begin
            push_one(8'hA0 + 8'(i), 1'b0, 1'b0);
        end
        chk("t3_count_full", 32'(count),    32'd4);
        chk("t3_ready_full", 32'(in_ready), 32'd0);
        push_one(8'hA4, 1'b0, 1'b0);
        chk("t3_drop",       32'(drop_err), 32'd1);
        chk("t3_count_keep", 32'(count),    32'd4);
        chk("t3_head_keep",  32'(out_data), 32'hA0);
        // full + capture + pop: pop only, capture dropped
        capture = 1'b1;
        y_in    = 8'hEE;
        pop     = 1'b1;
        step();
        capture = 1'b0;
        pop     = 1'b0;
        chk("t3_fullcp_count", 32'(count),    32'd3);
        chk("t3_fullcp_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            chk("t3_pop_data", 32'(out_data), 32'hA0 + 32'(i));
            pop_one();
        end
        chk("t3_end_valid", 32'(out_valid), 32'd0);
        chk("t3_drop_sticky", 32'(drop_err), 32'd1);
        do_clr();
        chk("clr_drop",  32'(drop_err), 32'd0);
        chk("clr_count", 32'(count),    32'd0);

        // clr beats a simultaneous capture
        push_one(8'h55, 1'b1, 1'b1);
        capture = 1'b1;
        y_in    = 8'h66;
        clr     = 1'b1;
        step();
        capture = 1'b0;
        clr     = 1'b0;
        chk("clr_prio_count", 32'(count),     32'd0);
        chk("clr_prio_valid", 32'(out_valid), 32'd0);

        // 4. Simultaneous push and pop with count=2
        push_one(8'hB0, 1'b0, 1'b0);
        push_one(8'hB1, 1'b0, 1'b1);
        capture  = 1'b1;
        y_in     = 8'hB2;
        zero_in  = 1'b1;
        carry_in = 1'b0;
        pop      = 1'b1;
        step();
        capture  = 1'b0;
        pop      = 1'b0;
        chk("t4_count", 32'(count), 32'd2);
        chk_head("t4_h1", 8'hB1, 1'b0, 1'b1);
        pop_one();
        chk_head("t4_h2", 8'hB2, 1'b1, 1'b0);
        pop_one();
        chk("t4_empty", 32'(out_valid), 32'd0);

        // Empty + capture + pop: push only
        capture  = 1'b1;
        y_in     = 8'hC0;
        zero_in  = 1'b0;
        carry_in = 1'b0;
        pop      = 1'b1;
        step();
        capture  = 1'b0;
        pop      = 1'b0;
        chk("ecp_count", 32'(count),    32'd1);
        chk("ecp_data",  32'(out_data), 32'hC0);

        // 5. Async reset mid-cycle with entries stored
        push_one(8'hD1, 1'b1, 1'b1);
        push_one(8'hD2, 1'b0, 1'b1);
        chk("t5_count_pre", 32'(count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", 32'(count),     32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data",  32'(out_data),  32'h00);
        chk("t5_rst_zero",  32'(out_zero),  32'd0);
        chk("t5_rst_ready", 32'(in_ready),  32'd1);
        #1;
        rst_n = 1'b1;
        step();
        pop_one();
        chk("t5_post_count", 32'(count),     32'd0);
        chk("t5_post_valid", 32'(out_valid), 32'd0);
        chk("t5_post_drop",  32'(drop_err),  32'd0);

`ifdef RESULT_ACC_EN
        // 6. Accumulator wrap: 257 * 0xFF = 0xFFFF, +1 wraps to 0
        do_clr();
        capture  = 1'b1;
        y_in     = 8'hFF;
        zero_in  = 1'b0;
        carry_in = 1'b0;
        pop      = 1'b1;
        for (int i = 0; i < 257; i++) begin
            step();
        end
        capture = 1'b0;
        pop     = 1'b0;
        chk("t6_acc_ffff", 32'(acc_sum), 32'hFFFF);
        push_one(8'h01, 1'b0, 1'b0);
        chk("t6_acc_wrap", 32'(acc_sum), 32'h0000);
        push_one(8'h10, 1'b0, 1'b0);
        chk("t6_acc_add", 32'(acc_sum), 32'h0010);
        do_clr();
        chk("t6_acc_clr", 32'(acc_sum), 32'h0000);
`else
        // Accumulator absent: acc_sum stays zero even after pushes
        push_one(8'h7F, 1'b0, 1'b0);
        chk("noacc_zero", 32'(acc_sum), 32'h0000);
        chk("noacc_count", 32'(count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
